// File: rtl/time_mode_ctrl.sv
// time_mode_ctrl: timekeeping and RUN/SET mode controller for the digital clock.
// Consumes the 1 Hz square wave and two raw buttons in the Clock_5K domain, keeps
// Hour/Min/Sec, and walks RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN on mode presses.
// Optional feature macro: TIME_CTRL_BLINK_EN (field blink mask for the display).
module time_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int DB_W            = 7,
  parameter int HOUR_MAX        = 23
) (
  input  logic       Clock_5K,
  input  logic       Reset,
  input  logic       Clock_1Sec,
  input  logic       Mode_Btn,
  input  logic       Up_Btn,
  output logic [4:0] Hour,
  output logic [5:0] Min,
  output logic [5:0] Sec,
  output logic [1:0] Mode,
  output logic       Sec_Pulse,
  output logic [2:0] Blink_Mask
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]      HOUR_LAST = 5'(HOUR_MAX);

  state_t          state, state_n;
  logic            prev_1s;
  logic            tick;
  logic [1:0]      raw_btn, sync_a, sync_b, db_level, db_prev, press;
  logic [DB_W-1:0] db_cnt [2];
  logic            mode_press, up_press;
  logic [4:0]      hour_n, hour_inc;
  logic [5:0]      min_n, min_inc, sec_n, sec_inc;
  logic            sec_pulse_n;

  // Bit 0 carries the mode button, bit 1 the up button through the shared path
  assign raw_btn    = {Up_Btn, Mode_Btn};
  assign mode_press = press[0];
  assign up_press   = press[1];
  assign tick       = Clock_1Sec & ~prev_1s;
  assign Mode       = state;

  assign hour_inc = (Hour == HOUR_LAST) ? 5'd0 : Hour + 5'd1;
  assign min_inc  = (Min == 6'd59) ? 6'd0 : Min + 6'd1;
  assign sec_inc  = (Sec == 6'd59) ? 6'd0 : Sec + 6'd1;

  // Synchronise, debounce and edge-detect both buttons; press is a registered one-cycle strobe
  always_ff @(posedge Clock_5K) begin
    if (Reset) begin
      sync_a    <= '0;
      sync_b    <= '0;
      db_level  <= '0;
      db_prev   <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_a  <= raw_btn;
      sync_b  <= sync_a;
      db_prev <= db_level;
      press   <= db_level & ~db_prev;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]   <= '0;
          db_level[i] <= sync_b[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Remember the previous 1 Hz level so a rising edge yields exactly one tick
  always_ff @(posedge Clock_5K) begin
    if (Reset) prev_1s <= 1'b0;
    else       prev_1s <= Clock_1Sec;
  end

  // Mode state and time registers
  always_ff @(posedge Clock_5K) begin
    if (Reset) begin
      state     <= RUN;
      Hour      <= '0;
      Min       <= '0;
      Sec       <= '0;
      Sec_Pulse <= 1'b0;
    end else begin
      state     <= state_n;
      Hour      <= hour_n;
      Min       <= min_n;
      Sec       <= sec_n;
      Sec_Pulse <= sec_pulse_n;
    end
  end

  // Next mode and time: RUN counts with full carry, SET modes edit one field; mode press beats up press
  always_comb begin
    state_n     = state;
    hour_n      = Hour;
    min_n       = Min;
    sec_n       = Sec;
    sec_pulse_n = 1'b0;
    case (state)
      RUN: begin
        if (tick) begin
          sec_pulse_n = 1'b1;
          sec_n       = sec_inc;
          if (Sec == 6'd59) begin
            min_n = min_inc;
            if (Min == 6'd59) hour_n = hour_inc;
          end
        end
        if (mode_press) state_n = SET_HOUR;
      end
      SET_HOUR: begin
        if (mode_press)    state_n = SET_MIN;
        else if (up_press) hour_n  = hour_inc;
      end
      SET_MIN: begin
        if (mode_press)    state_n = SET_SEC;
        else if (up_press) min_n   = min_inc;
      end
      SET_SEC: begin
        if (mode_press)    state_n = RUN;
        else if (up_press) sec_n   = 6'd0;
      end
      default: state_n = RUN;
    endcase
  end

`ifdef TIME_CTRL_BLINK_EN
  logic       blink_hold, blink_hold_n;
  logic [2:0] mask_n;

  // Selected field follows the 1 Hz level; an up press keeps it visible until the next tick
  always_comb begin
    blink_hold_n = blink_hold;
    if (up_press)  blink_hold_n = 1'b1;
    else if (tick) blink_hold_n = 1'b0;
    case (state_n)
      SET_HOUR: mask_n = 3'b100;
      SET_MIN:  mask_n = 3'b010;
      SET_SEC:  mask_n = 3'b001;
      default:  mask_n = 3'b000;
    endcase
    if (blink_hold_n || !Clock_1Sec) mask_n = 3'b000;
  end

  // Register the blink mask together with the hold flag
  always_ff @(posedge Clock_5K) begin
    if (Reset) begin
      blink_hold <= 1'b0;
      Blink_Mask <= 3'b000;
    end else begin
      blink_hold <= blink_hold_n;
      Blink_Mask <= mask_n;
    end
  end
`else
  assign Blink_Mask = 3'b000;
`endif

endmodule

// File: tb/tb_time_mode_ctrl.sv
// tb_time_mode_ctrl: self-checking bench for time_mode_ctrl.
// Table-driven vectors, hand sequences for debounce timing and corner cases,
// and randomized operations checked against a seconds-of-day reference model.
module tb_time_mode_ctrl;

  logic       Clock_5K   = 1'b0;
  logic       Reset      = 1'b1;
  logic       Clock_1Sec = 1'b0;
  logic       Mode_Btn   = 1'b0;
  logic       Up_Btn     = 1'b0;
  logic [4:0] Hour;
  logic [5:0] Min;
  logic [5:0] Sec;
  logic [1:0] Mode;
  logic       Sec_Pulse;
  logic [2:0] Blink_Mask;

  localparam int OP_TICK = 0;
  localparam int OP_MODE = 1;
  localparam int OP_UP   = 2;

`ifdef TIME_CTRL_BLINK_EN
  localparam int BLINK_HOUR_HI = 4;
`else
  localparam int BLINK_HOUR_HI = 0;
`endif

  typedef struct {
    int op;
    int count;
    int exp_h;
    int exp_m;
    int exp_s;
    int exp_mode;
  } vec_t;

  vec_t vecs [12];

  int checks       = 0;
  int failures     = 0;
  int pulse_count  = 0;
  int pulse_base   = 0;
  int model_t      = 0;
  int model_mode   = 0;
  int model_pulses = 0;

  time_mode_ctrl dut (
    .Clock_5K  (Clock_5K),
    .Reset     (Reset),
    .Clock_1Sec(Clock_1Sec),
    .Mode_Btn  (Mode_Btn),
    .Up_Btn    (Up_Btn),
    .Hour      (Hour),
    .Min       (Min),
    .Sec       (Sec),
    .Mode      (Mode),
    .Sec_Pulse (Sec_Pulse),
    .Blink_Mask(Blink_Mask)
  );

  // 5 kHz system clock (time units are arbitrary)
  always #5 Clock_5K = ~Clock_5K;

  // Count every second strobe seen outside reset
  always @(negedge Clock_5K) begin
    if (!Reset && Sec_Pulse) pulse_count++;
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s, input int md);
    check_output({tag, "_hour"}, int'(Hour), h);
    check_output({tag, "_min"},  int'(Min),  m);
    check_output({tag, "_sec"},  int'(Sec),  s);
    check_output({tag, "_mode"}, int'(Mode), md);
  endtask

  task automatic check_model(input string tag);
    check_time(tag, model_t / 3600, (model_t / 60) % 60, model_t % 60, model_mode);
  endtask

  // Reference model: time as seconds of day, mode as 0..3
  task automatic model_apply(input int op);
    int h, m, s;
    h = model_t / 3600;
    m = (model_t / 60) % 60;
    s = model_t % 60;
    case (op)
      OP_TICK: begin
        if (model_mode == 0) begin
          model_t = (model_t + 1) % 86400;
          model_pulses++;
        end
      end
      OP_MODE: model_mode = (model_mode + 1) % 4;
      default: begin
        if (model_mode == 1)      h = (h + 1) % 24;
        else if (model_mode == 2) m = (m + 1) % 60;
        else if (model_mode == 3) s = 0;
        model_t = h * 3600 + m * 60 + s;
      end
    endcase
  endtask

  task automatic do_tick(input int hi, input int lo);
    @(negedge Clock_5K);
    Clock_1Sec = 1'b1;
    repeat (hi) @(negedge Clock_5K);
    Clock_1Sec = 1'b0;
    repeat (lo) @(negedge Clock_5K);
  endtask

  task automatic do_press(input int op, input int hold);
    @(negedge Clock_5K);
    if (op == OP_MODE) Mode_Btn = 1'b1;
    else               Up_Btn   = 1'b1;
    repeat (hold) @(negedge Clock_5K);
    Mode_Btn = 1'b0;
    Up_Btn   = 1'b0;
    repeat (110) @(negedge Clock_5K);
  endtask

  task automatic apply_stimulus(input int op, input int count);
    for (int i = 0; i < count; i++) begin
      if (op == OP_TICK) do_tick($urandom_range(2, 5), $urandom_range(2, 5));
      else               do_press(op, 110);
      model_apply(op);
    end
  endtask

  task automatic do_reset();
    @(negedge Clock_5K);
    Reset      = 1'b1;
    Mode_Btn   = 1'b0;
    Up_Btn     = 1'b0;
    Clock_1Sec = 1'b0;
    repeat (2) @(negedge Clock_5K);
    Reset        = 1'b0;
    model_t      = 0;
    model_mode   = 0;
    model_pulses = 0;
    pulse_base   = pulse_count;
  endtask

  initial begin
    int lat;
    int r;

    vecs[0]  = '{OP_TICK, 3,  0,  0,  3, 0};
    vecs[1]  = '{OP_TICK, 55, 0,  0,  58, 0};
    vecs[2]  = '{OP_MODE, 1,  0,  0,  58, 1};
    vecs[3]  = '{OP_UP,   23, 23, 0,  58, 1};
    vecs[4]  = '{OP_TICK, 3,  23, 0,  58, 1};
    vecs[5]  = '{OP_MODE, 1,  23, 0,  58, 2};
    vecs[6]  = '{OP_UP,   59, 23, 59, 58, 2};
    vecs[7]  = '{OP_TICK, 2,  23, 59, 58, 2};
    vecs[8]  = '{OP_UP,   1,  23, 0,  58, 2};
    vecs[9]  = '{OP_UP,   59, 23, 59, 58, 2};
    vecs[10] = '{OP_MODE, 2,  23, 59, 58, 0};
    vecs[11] = '{OP_TICK, 1,  23, 59, 59, 0};

    // Reset held for two edges clears everything
    repeat (2) @(negedge Clock_5K);
    check_time("reset", 0, 0, 0, 0);
    check_output("reset_pulse", int'(Sec_Pulse), 0);
    check_output("reset_blink", int'(Blink_Mask), 0);
    Reset = 1'b0;
    repeat (5) @(negedge Clock_5K);

    // Mode press latency measured from the first edge that samples the button high
    Mode_Btn = 1'b1;
    @(posedge Clock_5K);
    lat = -1;
    for (int k = 1; k <= 140; k++) begin
      @(posedge Clock_5K);
      #1;
      if (lat < 0 && Mode == 2'd1) lat = k;
    end
    repeat (9) @(negedge Clock_5K);
    Mode_Btn = 1'b0;
    check_output("mode_press_latency", lat, 103);
    repeat (120) @(negedge Clock_5K);
    check_output("mode_after_press", int'(Mode), 1);

    // A short glitch must be rejected
    Mode_Btn = 1'b1;
    repeat (50) @(negedge Clock_5K);
    Mode_Btn = 1'b0;
    repeat (200) @(negedge Clock_5K);
    check_output("glitch_mode", int'(Mode), 1);

    // Hour to 5, then simultaneous mode and up presses: mode wins
    for (int i = 0; i < 5; i++) do_press(OP_UP, 110);
    check_time("hour5", 5, 0, 0, 1);
    @(negedge Clock_5K);
    Mode_Btn = 1'b1;
    Up_Btn   = 1'b1;
    repeat (110) @(negedge Clock_5K);
    Mode_Btn = 1'b0;
    Up_Btn   = 1'b0;
    repeat (110) @(negedge Clock_5K);
    check_time("same_cycle", 5, 0, 0, 2);

    // Reset in SET_SEC while an up press is pending
    do_press(OP_MODE, 110);
    check_output("set_sec_mode", int'(Mode), 3);
    Up_Btn = 1'b1;
    repeat (60) @(negedge Clock_5K);
    Reset = 1'b1;
    @(posedge Clock_5K);
    #1;
    check_time("mid_reset", 0, 0, 0, 0);
    @(negedge Clock_5K);
    Up_Btn = 1'b0;
    repeat (3) @(negedge Clock_5K);
    Reset = 1'b0;
    repeat (150) @(negedge Clock_5K);
    check_time("after_mid_reset", 0, 0, 0, 0);

    // Blink mask in SET_HOUR follows the 1 Hz level when the feature is built in
    do_press(OP_MODE, 110);
    @(negedge Clock_5K);
    Clock_1Sec = 1'b1;
    repeat (3) @(negedge Clock_5K);
    check_output("blink_hour_hi", int'(Blink_Mask), BLINK_HOUR_HI);
    Clock_1Sec = 1'b0;
    repeat (3) @(negedge Clock_5K);
    check_output("blink_hour_lo", int'(Blink_Mask), 0);

    // Table-driven sequence from a fresh reset up to 23:59:59
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].count);
      check_time($sformatf("vec%0d", i), vecs[i].exp_h, vecs[i].exp_m, vecs[i].exp_s, vecs[i].exp_mode);
      if (i == 0) check_output("pulses_after_3_ticks", pulse_count - pulse_base, 3);
    end
    check_output("table_pulses", pulse_count - pulse_base, model_pulses);

    // Full rollover resolves on a single edge with one strobe
    @(negedge Clock_5K);
    Clock_1Sec = 1'b1;
    @(posedge Clock_5K);
    #1;
    check_time("rollover", 0, 0, 0, 0);
    check_output("rollover_pulse", int'(Sec_Pulse), 1);
    @(posedge Clock_5K);
    #1;
    check_output("rollover_pulse_width", int'(Sec_Pulse), 0);
    repeat (3) @(negedge Clock_5K);
    Clock_1Sec = 1'b0;
    repeat (3) @(negedge Clock_5K);
    model_apply(OP_TICK);

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 3));
      if (r <= 1)      apply_stimulus(OP_TICK, 1);
      else if (r == 2) apply_stimulus(OP_MODE, 1);
      else             apply_stimulus(OP_UP, 1);
      check_model($sformatf("rand%0d", n));
    end
    check_output("total_pulses", pulse_count - pulse_base, model_pulses);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
